// File: rtl/uart_pkg.sv
// Shared UART definitions: default byte width and the feeder controller state encoding.
package uart_pkg;

  localparam int UART_DW = 8;

  typedef enum logic [1:0] {
    FD_IDLE    = 2'd0,
    FD_LAUNCH  = 2'd1,
    FD_SENDING = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO without fall-through: head shows the oldest stored entry, pointers wrap modulo DEPTH.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DW    = UART_DW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [DW-1:0]              din,
  input  logic                       pop,
  output logic [DW-1:0]              head,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          push_ok;
  logic          pop_ok;

  // Flush wins over both sides so a write in the flush cycle is dropped.
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));
  assign head  = mem[rptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + AW'(1);
      end
      if (pop_ok) begin
        rptr <= rptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte queue plus launch controller in front of the UART transmitter: holds tx_start until the
// transmitter acknowledges with tx_busy, waits for it to finish, and flags drops and stuck launches.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int DW      = UART_DW,
  parameter int TIMEOUT = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   wr_valid,
  input  logic [DW-1:0]          wr_data,
  output logic                   wr_ready,
  input  logic                   tx_busy,
  output logic                   tx_start,
  output logic [DW-1:0]          tx_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow,
  output logic                   launch_err,
  output logic [1:0]             state_dbg
);

  // Host handshake: a byte transfers on a rising edge where wr_valid && wr_ready; wr_ready is
  // simply !full and ignores any pop happening in the same cycle.

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  feeder_state_t state;
  feeder_state_t state_nxt;
  logic [CW-1:0] tcnt;
  logic [DW-1:0] head;
  logic          pop_req;
  logic          timeout_hit;

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (wr_valid),
    .din   (wr_data),
    .pop   (pop_req),
    .head  (head),
    .level (level),
    .empty (empty),
    .full  (full)
  );

  assign wr_ready    = !full;
  assign state_dbg   = state;
  assign timeout_hit = (state == FD_LAUNCH) && !tx_busy && (tcnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FD_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = FD_IDLE;
    case (state)
      FD_IDLE: begin
        state_nxt = (!empty && !tx_busy) ? FD_LAUNCH : FD_IDLE;
      end
      FD_LAUNCH: begin
        if (tx_busy) begin
          state_nxt = FD_SENDING;
        end else if (timeout_hit) begin
          state_nxt = FD_IDLE;
        end else begin
          state_nxt = FD_LAUNCH;
        end
      end
      FD_SENDING: begin
        state_nxt = tx_busy ? FD_SENDING : FD_IDLE;
      end
      default: begin
        state_nxt = FD_IDLE;
      end
    endcase
  end

  // An already busy transmitter (external launch) blocks the pop.
  always_comb begin
    tx_start = (state == FD_LAUNCH);
    pop_req  = (state == FD_IDLE) && !empty && !tx_busy;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data    <= '0;
      tcnt       <= '0;
      overflow   <= 1'b0;
      launch_err <= 1'b0;
    end else begin
      if (flush) begin
        overflow <= 1'b0;
      end else if (wr_valid && full) begin
        overflow <= 1'b1;
      end
      if (pop_req) begin
        tx_data <= head;
        tcnt    <= '0;
      end else if ((state == FD_LAUNCH) && !tx_busy && !timeout_hit) begin
        tcnt <= tcnt + CW'(1);
      end
      if (timeout_hit) begin
        launch_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed and randomized bench for uart_tx_feeder with a baud-paced transmitter model and a byte scoreboard.
module tb_uart_tx_feeder;

  localparam int DEPTH   = 16;
  localparam int DW      = 8;
  localparam int TIMEOUT = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          tx_busy;
  logic          tx_start;
  logic [DW-1:0] tx_data;
  logic [4:0]    level;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          launch_err;
  logic [1:0]    state_dbg;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] rx_q[$];

  // transmitter model: accepts tx_start on baud ticks (every 4 clocks), stays busy for 10 bit times
  logic       xmit_en;
  logic       drv_busy;
  logic       m_busy;
  logic [1:0] baud_cnt;
  logic [3:0] bits_left;
  logic       busy_prev;
  int         viol;

  assign tx_busy = xmit_en ? m_busy : drv_busy;

  always #5 clk = ~clk;

  uart_tx_feeder #(
    .DEPTH   (DEPTH),
    .DW      (DW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .tx_busy    (tx_busy),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .level      (level),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow),
    .launch_err (launch_err),
    .state_dbg  (state_dbg)
  );

  always @(posedge clk) begin
    if (rst) begin
      m_busy    <= 1'b0;
      baud_cnt  <= 2'd0;
      bits_left <= 4'd0;
    end else begin
      baud_cnt <= baud_cnt + 2'd1;
      if (baud_cnt == 2'd0 && xmit_en) begin
        if (!m_busy && tx_start) begin
          m_busy    <= 1'b1;
          bits_left <= 4'd10;
          rx_q.push_back(tx_data);
        end else if (m_busy) begin
          if (bits_left == 4'd1) m_busy <= 1'b0;
          bits_left <= bits_left - 4'd1;
        end
      end
    end
  end

  initial viol = 0;
  always @(posedge clk) begin
    if (xmit_en && tx_start && tx_busy && busy_prev) viol <= viol + 1;
    busy_prev <= tx_busy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_bytes(input int n, input logic [7:0] base, input logic [7:0] step);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr_valid = 1'b1;
      wr_data  = base + step * 8'(i);
      if (wr_ready) exp_q.push_back(wr_data);
    end
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n, input string tag);
    int k = 0;
    while (rx_q.size() < n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check(tag, rx_q.size(), n);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (!(!tx_busy && !tx_start && empty) && k < 500) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    check(tag, {tx_busy, tx_start, empty}, 3'b001);
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
    end
  endtask

  initial begin
    int run;
    int starts;
    int k;

    rst      = 1'b1;
    flush    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    xmit_en  = 1'b0;
    drv_busy = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_level", level, 0);
    check("rst_flags", {empty, full, wr_ready, overflow, launch_err}, 5'b10100);

    // 1: single byte latency
    xmit_en = 1'b1;
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = 8'hA5;
    @(negedge clk);
    wr_valid = 1'b0;
    check("t1_level_n1", level, 1);
    check("t1_start_n1", tx_start, 0);
    @(negedge clk);
    check("t1_start_n2", tx_start, 1);
    check("t1_data_n2", tx_data, 8'hA5);
    check("t1_empty_n2", empty, 1);
    wait_rx(1, "t1_rx_count");
    check("t1_rx_byte", rx_q[0], 8'hA5);
    wait_idle("t1_idle");

    // 2: fill to full with transmitter busy, then overflow
    xmit_en  = 1'b0;
    drv_busy = 1'b1;
    push_bytes(16, 8'h01, 8'h01);
    check("t2_full", {full, wr_ready}, 2'b10);
    check("t2_level", level, 16);
    check("t2_ovf_before", overflow, 0);
    push_bytes(1, 8'h11, 8'h00);
    check("t2_ovf", overflow, 1);
    check("t2_level_ovf", level, 16);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("t2_flush_level", level, 0);
    check("t2_flush_ovf", overflow, 0);
    drv_busy = 1'b0;
    repeat (3) @(negedge clk);
    check("t2_no_start", tx_start, 0);

    // 3: three bytes in order through the transmitter model
    xmit_en = 1'b1;
    exp_q.delete();
    rx_q.delete();
    push_bytes(3, 8'h11, 8'h11);
    wait_rx(3, "t3_rx_wait");
    check_stream("t3");
    wait_idle("t3_idle");

    // random bytes with random gaps against the scoreboard
    exp_q.delete();
    rx_q.delete();
    for (int i = 0; i < 20; i++) begin
      push_bytes(1, 8'($urandom_range(0, 255)), 8'h00);
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end
    wait_rx(exp_q.size(), "rnd_rx_wait");
    check_stream("rnd");
    wait_idle("rnd_idle");

    // 4: launch timeout with tx_busy stuck low
    xmit_en  = 1'b0;
    drv_busy = 1'b0;
    exp_q.delete();
    rx_q.delete();
    push_bytes(2, 8'h5A, 8'h11);
    run = 0;
    while (tx_start && run < 40) begin
      run++;
      @(negedge clk);
    end
    check("t4_start_len", run, TIMEOUT);
    check("t4_launch_err", launch_err, 1);
    check("t4_gap", tx_start, 0);
    xmit_en = 1'b1;
    @(negedge clk);
    check("t4_next_start", tx_start, 1);
    check("t4_next_data", tx_data, 8'h6B);
    wait_rx(1, "t4_rx_count");
    check("t4_rx_byte", rx_q[0], 8'h6B);
    wait_idle("t4_idle");

    // 5: flush while a byte is being sent
    exp_q.delete();
    rx_q.delete();
    push_bytes(6, 8'h40, 8'h01);
    k = 0;
    while (!(tx_busy && !tx_start) && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("t5_sending", {tx_busy, tx_start}, 2'b10);
    check("t5_level5", level, 5);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("t5_level0", level, 0);
    check("t5_ovf", overflow, 0);
    starts = 0;
    k = 0;
    while (tx_busy && k < 100) begin
      if (tx_start) starts++;
      @(negedge clk);
      k++;
    end
    repeat (10) begin
      if (tx_start) starts++;
      @(negedge clk);
    end
    check("t5_no_start", starts, 0);
    check("t5_rx_count", rx_q.size(), 1);
    check("t5_rx_byte", rx_q[0], 8'h40);

    // 6: reset mid-LAUNCH, then simultaneous write and pop
    xmit_en  = 1'b0;
    drv_busy = 1'b0;
    push_bytes(4, 8'h70, 8'h01);
    check("t6_pre_level", level, 3);
    check("t6_pre_start", tx_start, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst_start", tx_start, 0);
    check("t6_rst_level", level, 0);
    check("t6_rst_flags", {empty, overflow, launch_err}, 3'b100);
    check("t6_rst_data", tx_data, 0);
    drv_busy = 1'b1;
    push_bytes(4, 8'h80, 8'h01);
    check("t6_level4", level, 4);
    drv_busy = 1'b0;
    wr_valid = 1'b1;
    wr_data  = 8'h90;
    @(negedge clk);
    wr_valid = 1'b0;
    check("t6_pushpop_level", level, 4);
    check("t6_pushpop_start", tx_start, 1);
    check("t6_pushpop_data", tx_data, 8'h80);

    check("start_after_ack", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
